// File: rtl/bit_extract64_pkg.sv
// Shared ALU constants and types for the set-bit extraction path.
package bit_extract64_pkg;

  localparam int WIDTH = 64;
  localparam int IDXW  = 6;
  localparam int SEQW  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/bit_extract64_if.sv
// Word-in / index-out handshake bundle for bit_extract64.
interface bit_extract64_if;
  import bit_extract64_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_word;
  logic              out_valid;
  logic              out_ready;
  logic [IDXW-1:0]   out_idx;
  logic              out_last;
  logic              out_zero;
  logic [SEQW-1:0]   out_seq;
  logic              busy;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero, out_seq, busy
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero, out_seq, busy
  );
endinterface

// File: rtl/bit_extract64_lsb_index64.sv
// Combinational 64-to-6 lowest-set-bit priority encoder, reusable for
// count-trailing-zeros style operations.
module lsb_index64
  import bit_extract64_pkg::*;
(
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             found_o
);

  // Scanning from the top down lets the lowest set bit win the last write.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDXW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bit_extract64.sv
// Accepts a 64-bit word and streams the index of each set bit, lowest first,
// one beat per cycle; an all-zero word yields one beat flagged by out_zero.
module bit_extract64
  import bit_extract64_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  bit_extract64_if.slave  bus
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [SEQW-1:0]   seq_q, seq_d;
  logic              zero_q, zero_d;

  logic [IDXW-1:0]   lowIdx;
  logic              lowFound;
  logic              lastBeat;
  logic              accept;
  logic              beat;

  lsb_index64 u_lsb (
    .vec_i   (mask_q),
    .idx_o   (lowIdx),
    .found_o (lowFound)
  );

  assign lastBeat = zero_q | ((mask_q & (mask_q - WIDTH'(1))) == '0);
  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign beat     = (state_q == SCAN) && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      seq_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      seq_q   <= seq_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (beat && lastBeat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    seq_d  = seq_q;
    zero_d = zero_q;
    if (accept) begin
      mask_d = bus.in_word;
      zero_d = (bus.in_word == '0);
      seq_d  = '0;
    end else if (beat) begin
      mask_d = mask_q & ~(WIDTH'(1) << lowIdx);
      seq_d  = seq_q + SEQW'(1);
    end
  end

  // Beat fields are gated to zero outside SCAN so IDLE always shows reset values.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    bus.out_zero  = 1'b0;
    bus.out_seq   = '0;
    unique case (state_q)
      IDLE: bus.in_ready = 1'b1;
      SCAN: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.out_idx   = lowFound ? lowIdx : '0;
        bus.out_last  = lastBeat;
        bus.out_zero  = zero_q;
        bus.out_seq   = seq_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bit_extract64.sv
// Randomized and directed checks of bit_extract64 against a set-bit list model.
module tb_bit_extract64;

  typedef logic [14:0] beat_t;
  typedef beat_t beatq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  bit_extract64_if bif ();

  bit_extract64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Expected beats: {idx, last, zero, seq} for every set bit, lowest first.
  function automatic beatq_t model_beats(input logic [63:0] word);
    beatq_t q;
    int     idxList[$];
    for (int i = 0; i < 64; i++)
      if (((word >> i) & 64'd1) != 64'd0) idxList.push_back(i);
    if (idxList.size() == 0) begin
      q.push_back({6'd0, 1'b1, 1'b1, 7'd0});
    end else begin
      for (int p = 0; p < idxList.size(); p++)
        q.push_back({6'(idxList[p]), (p == idxList.size() - 1), 1'b0, 7'(p)});
    end
    return q;
  endfunction

  function automatic beat_t observed();
    return {bif.out_idx, bif.out_last, bif.out_zero, bif.out_seq};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] word);
    bif.in_word  = word;
    bif.in_valid = 1'b1;
    step();
    bif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_word = '0;
    bif.out_ready = 1'b0;
    step();
    step();
    total++;
    if ({bif.in_ready, bif.out_valid, bif.busy, observed()} !== {3'b100, 15'd0}) begin
      bad++;
      $display("[TB] FAIL reset: got rdy/val/busy=%b beat=%h want 100 beat=0000",
               {bif.in_ready, bif.out_valid, bif.busy}, observed());
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero_word();
    bif.out_ready = 1'b1;
    send_word(64'd0);
    total++;
    if ({bif.out_valid, bif.in_ready, observed()} !== {2'b10, 6'd0, 1'b1, 1'b1, 7'd0}) begin
      bad++;
      $display("[TB] FAIL zero_beat: got val/rdy=%b beat=%h", {bif.out_valid, bif.in_ready}, observed());
    end
    step();
    total++;
    if ({bif.out_valid, bif.in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL zero_idle: got val/rdy=%b want 01", {bif.out_valid, bif.in_ready});
    end
  endtask

  task automatic test_sparse();
    beatq_t exp = model_beats(64'h8000_0000_0000_0011);
    bif.out_ready = 1'b1;
    send_word(64'h8000_0000_0000_0011);
    foreach (exp[p]) begin
      total++;
      if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0 || observed() !== exp[p]) begin
        bad++;
        $display("[TB] FAIL sparse_beat%0d: got val=%b beat=%h want beat=%h", p, bif.out_valid, observed(), exp[p]);
      end
      step();
    end
    total++;
    if ({bif.out_valid, bif.in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL sparse_idle: got val/rdy=%b want 01", {bif.out_valid, bif.in_ready});
    end
  endtask

  task automatic test_full();
    beatq_t exp = model_beats('1);
    int     errs = 0;
    bif.out_ready = 1'b1;
    send_word('1);
    foreach (exp[p]) begin
      total++;
      if (bif.out_valid !== 1'b1 || observed() !== exp[p]) begin
        bad++;
        errs++;
        if (errs < 5)
          $display("[TB] FAIL full_beat%0d: got val=%b beat=%h want beat=%h", p, bif.out_valid, observed(), exp[p]);
      end
      step();
    end
    total++;
    if (bif.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_end: got val=%b want 0", bif.out_valid);
    end
  endtask

  task automatic test_stall();
    logic readyPat[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    beatq_t exp = model_beats(64'hA0);
    int     pos = 0;
    send_word(64'hA0);
    for (int c = 0; c < 5; c++) begin
      bif.out_ready = readyPat[c];
      total++;
      if (bif.out_valid !== 1'b1 || observed() !== exp[pos]) begin
        bad++;
        $display("[TB] FAIL stall_cyc%0d: got val=%b beat=%h want beat=%h", c, bif.out_valid, observed(), exp[pos]);
      end
      if (readyPat[c]) pos++;
      step();
    end
    total++;
    if ({bif.out_valid, bif.in_ready} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL stall_idle: got val/rdy=%b want 01", {bif.out_valid, bif.in_ready});
    end
  endtask

  task automatic test_random_words();
    for (int w = 0; w < 8; w++) begin
      logic [63:0] word;
      beatq_t      exp;
      int          pos = 0;
      int          cycles = 0;
      word = {$urandom, $urandom};
      if (w % 2 == 1) word = word & {$urandom, $urandom} & {$urandom, $urandom};
      if (w == 3) word = 64'h8000_0000_0000_0000;
      exp = model_beats(word);
      send_word(word);
      while (pos < exp.size() && cycles < 400) begin
        bif.out_ready = 1'($urandom_range(0, 1));
        total++;
        if (bif.out_valid !== 1'b1 || observed() !== exp[pos]) begin
          bad++;
          $display("[TB] FAIL rand_w%0d_p%0d: got val=%b beat=%h want beat=%h", w, pos, bif.out_valid, observed(), exp[pos]);
        end
        if (bif.out_ready) pos++;
        step();
        cycles++;
      end
      total++;
      if (cycles >= 400 || bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL rand_w%0d_end: got val/rdy=%b cycles=%0d want 01", w, {bif.out_valid, bif.in_ready}, cycles);
      end
    end
  endtask

  task automatic test_reset_mid();
    bif.out_ready = 1'b1;
    send_word(64'h0F);
    step();
    step();
    rst_n = 1'b0;
    step();
    total++;
    if ({bif.in_ready, bif.out_valid, bif.busy, observed()} !== {3'b100, 15'd0}) begin
      bad++;
      $display("[TB] FAIL midreset: got rdy/val/busy=%b beat=%h want 100 beat=0000",
               {bif.in_ready, bif.out_valid, bif.busy}, observed());
    end
    rst_n = 1'b1;
    step();
    send_word(64'h2);
    total++;
    if (bif.out_valid !== 1'b1 || observed() !== {6'd1, 1'b1, 1'b0, 7'd0}) begin
      bad++;
      $display("[TB] FAIL postreset_beat: got val=%b beat=%h want beat=%h", bif.out_valid, observed(),
               {6'd1, 1'b1, 1'b0, 7'd0});
    end
    step();
    total++;
    if (bif.out_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL postreset_end: got val=%b want 0", bif.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wordA = 64'h0000_0100_0000_8001;
    logic [63:0] wordB = 64'h6;
    beatq_t      exp = model_beats(wordA);
    beatq_t      expB = model_beats(wordB);
    int          pos = 0;
    int          accepts = 0;
    int          firstB = -1;
    foreach (expB[i]) exp.push_back(expB[i]);
    bif.out_ready = 1'b1;
    bif.in_word = wordA;
    bif.in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      logic took;
      took = bif.in_ready && bif.in_valid;
      if (bif.out_valid) begin
        total++;
        if (pos >= exp.size() || observed() !== exp[pos]) begin
          bad++;
          $display("[TB] FAIL b2b_c%0d: got beat=%h at pos %0d", c, observed(), pos);
        end
        if (pos == 3) firstB = c;
        pos++;
      end
      step();
      if (took) begin
        accepts++;
        if (accepts == 1) bif.in_word = wordB;
        else bif.in_valid = 1'b0;
      end
    end
    total++;
    if (accepts !== 2 || pos !== exp.size() || firstB !== 5) begin
      bad++;
      $display("[TB] FAIL b2b_count: got accepts=%0d beats=%0d firstB=%0d want 2 %0d 5",
               accepts, pos, firstB, exp.size());
    end
  endtask

  initial begin
    bif.in_valid = 1'b0;
    bif.in_word = '0;
    bif.out_ready = 1'b0;
    test_reset();
    test_zero_word();
    test_sparse();
    test_full();
    test_stall();
    test_random_words();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
